// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback path.
//   REG_W / DATA_W : register address and writeback data widths
//   REG_ZERO       : hard-wired zero register, never written
//   wb_entry_t     : one queued writeback (live flag, destination, data)
package wb_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              live;
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Circular buffer of pending load writebacks.
// Each entry carries a live bit. A live bit is cleared when a younger ALU
// write hits the same register, so the stale load is drained without writing.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   push, push_entry     enqueue (ignored when full); push_entry.live is the
//                        requested live state before the kill check
//   pop                  dequeue head (ignored when empty)
//   kill_en, kill_addr   clear live bits of all entries targeting kill_addr,
//                        including an entry pushed in the same cycle
//   chk_addr1/2          CAM lookup addresses; chk_hit1/2 = live match
//   head                 oldest entry (live=0 when empty)
//   count, full, empty   occupancy, dead-but-unpopped entries included
module wb_load_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  wb_entry_t                  push_entry,
    input  logic                       pop,
    input  logic                       kill_en,
    input  logic [REG_W-1:0]           kill_addr,
    input  logic [REG_W-1:0]           chk_addr1,
    input  logic [REG_W-1:0]           chk_addr2,
    output logic                       chk_hit1,
    output logic                       chk_hit2,
    output wb_entry_t                  head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  live_q, live_d;
    logic [REG_W-1:0]  addr_q [DEPTH];
    logic [REG_W-1:0]  addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    logic push_ok;
    logic pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Live bits are cleared on pop, so a stale slot always reads as dead.
    assign head = '{live: live_q[rd_ptr_q], addr: addr_q[rd_ptr_q], data: data_q[rd_ptr_q]};

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        live_d   = live_q;
        addr_d   = addr_q;
        data_d   = data_q;

        if (kill_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr_q[i] == kill_addr) live_d[i] = 1'b0;
            end
        end

        if (pop_ok) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + 1'b1;
        end

        // A same-cycle ALU write to the same register is younger in program
        // order, so the incoming load lands already dead.
        if (push_ok) begin
            addr_d[wr_ptr_q] = push_entry.addr;
            data_d[wr_ptr_q] = push_entry.data;
            live_d[wr_ptr_q] = push_entry.live &&
                               !(kill_en && (push_entry.addr == kill_addr));
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            live_q   <= live_d;
        end
    end

    // NOTE: payload storage has no reset; a slot is only observed through its
    // live bit, which is reset, so clearing the data would just cost area.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    always_comb begin
        chk_hit1 = 1'b0;
        chk_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (addr_q[i] == chk_addr1)) chk_hit1 = 1'b1;
            if (live_q[i] && (addr_q[i] == chk_addr2)) chk_hit2 = 1'b1;
        end
        if (chk_addr1 == REG_ZERO) chk_hit1 = 1'b0;
        if (chk_addr2 == REG_ZERO) chk_hit2 = 1'b0;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Sole driver of the register-file write port. Merges single-cycle ALU
// results (no backpressure, always win) with buffered load responses, kills
// queued loads overwritten by younger ALU writes, and raises stall_req when
// the load queue is full or a live load has been starved too long.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   alu_valid/alu_reg/alu_data       ALU writeback
//   ld_valid/ld_ready/ld_reg/ld_data load response handshake
//   stall_req                        upstream must hold alu_valid low
//   chk_reg1/2 -> chk_pend1/2        pending live load lookup for decode
//   writeEnb/writeReg/writeData      registered regfile write port
//   proto_err                        sticky: alu_valid seen while stalled
module wb_port_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8,
    parameter int DATA_W     = wb_pkg::DATA_W,
    parameter int REG_W      = wb_pkg::REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [REG_W-1:0]  alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [REG_W-1:0]  ld_reg,
    input  logic [DATA_W-1:0] ld_data,
    output logic              stall_req,
    input  logic [REG_W-1:0]  chk_reg1,
    input  logic [REG_W-1:0]  chk_reg2,
    output logic              chk_pend1,
    output logic              chk_pend2,
    output logic              writeEnb,
    output logic [REG_W-1:0]  writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic              proto_err
);

    import wb_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ST_W  = $clog2(STARVE_MAX + 1);

    logic              write_enb_q, write_enb_d;
    logic [REG_W-1:0]  write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [ST_W-1:0]   starve_q, starve_d;
    logic              proto_err_q, proto_err_d;

    wb_entry_t         push_entry;
    wb_entry_t         head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              alu_win;
    logic              head_write;
    logic              empty_next;

    assign alu_win    = alu_valid && (alu_reg != REG_ZERO);
    assign ld_ready   = !fifo_full;
    // Loads to the zero register complete the handshake but are dropped.
    assign fifo_push  = ld_valid && ld_ready && (ld_reg != REG_ZERO);
    // The ALU owns the port when it writes; otherwise the head drains,
    // dead heads included (those pop without a write).
    assign fifo_pop   = !alu_win && !fifo_empty;
    assign head_write = fifo_pop && head.live;
    assign push_entry = '{live: 1'b1, addr: ld_reg, data: ld_data};

    assign stall_req  = fifo_full || (starve_q >= ST_W'(STARVE_MAX));

    assign empty_next = ((fifo_count == '0) && !fifo_push) ||
                        ((fifo_count == CNT_W'(1)) && fifo_pop && !fifo_push);

    wb_load_fifo #(
        .DEPTH (DEPTH)
    ) u_load_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .kill_en    (alu_win),
        .kill_addr  (alu_reg),
        .chk_addr1  (chk_reg1),
        .chk_addr2  (chk_reg2),
        .chk_hit1   (chk_pend1),
        .chk_hit2   (chk_pend2),
        .head       (head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_comb begin
        write_enb_d  = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;

        if (alu_win) begin
            write_enb_d  = 1'b1;
            write_reg_d  = alu_reg;
            write_data_d = alu_data;
        end else if (head_write) begin
            write_enb_d  = 1'b1;
            write_reg_d  = head.addr;
            write_data_d = head.data;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (head_write || empty_next) begin
            starve_d = '0;
        end else if (!fifo_empty && head.live && alu_win &&
                     (starve_q < ST_W'(STARVE_MAX))) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // The ALU still wins while stalled; the violation is only recorded.
    assign proto_err_d = proto_err_q || (alu_valid && stall_req);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values computed by the combinational blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_enb_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            starve_q     <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            write_enb_q  <= write_enb_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            starve_q     <= starve_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign writeEnb  = write_enb_q;
    assign writeReg  = write_reg_q;
    assign writeData = write_data_q;
    assign proto_err = proto_err_q;

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Sole driver of the register file write port (writeEnb/writeReg/writeData).
- Merges two writeback sources into that port:
  - Single-cycle ALU results, which have no backpressure.
  - Multi-cycle load responses, which use valid/ready and are buffered in a small FIFO.
- Guarantees program-order-safe overwrites.
- Exports a pending-write lookup so decode can interlock on the rs/rt operands.

Parameters:
DEPTH, 4, load FIFO entries (power of 2, >=2)
STARVE_MAX, 8, consecutive ALU-won cycles with a live load waiting before stall_req asserts
DATA_W, 32, writeback data width
REG_W, 5, register address width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
alu_valid  in  1  ALU writeback this cycle
alu_reg  in  REG_W  ALU destination
alu_data  in  DATA_W  ALU result
ld_valid  in  1  load response offered
ld_ready  out  1  FIFO can accept (registered-state derived)
ld_reg  in  REG_W  load destination
ld_data  in  DATA_W  load data
stall_req  out  1  upstream must hold alu_valid low this cycle
chk_reg1  in  REG_W  decode operand 1 address
chk_reg2  in  REG_W  decode operand 2 address
chk_pend1  out  1  live queued load targets chk_reg1
chk_pend2  out  1  live queued load targets chk_reg2
writeEnb  out  1  regfile write enable (registered)
writeReg  out  REG_W  regfile write address (registered)
writeData  out  DATA_W  regfile write data (registered)
proto_err  out  1  sticky: alu_valid seen while stall_req high

Behaviour:
- Reset (async, rst=1): FIFO empty, all live bits 0, starve_cnt=0, writeEnb=0, writeReg=0, writeData=0, proto_err=0, ld_ready=1, stall_req=0.
- Register 0 (address 0) is never written:
  - ALU writes to reg 0 are ignored.
  - A load to reg 0 is accepted (handshake completes) but not enqueued.
- Enqueue occurs when ld_valid && ld_ready at the posedge.
  - ld_ready = (count < DEPTH).
  - count includes killed-but-unpopped entries.
- Kill rule, applied each cycle an ALU write to R≠0 is accepted:
  - Every queued entry with reg==R has its live bit cleared.
  - A load enqueued the same cycle with ld_reg==R is accepted but enqueued dead.
- Output select, evaluated each cycle; the next-cycle registered outputs are:
  - alu_valid && alu_reg≠0 → writeEnb=1, alu_reg, alu_data.
  - else head exists and head live → writeEnb=1, head reg, head data; pop.
  - else head exists and head dead → pop silently, writeEnb=0.
  - else → writeEnb=0. writeReg/writeData hold their last value.
- Latency:
  - ALU input at edge N → writeEnb high after edge N → regfile write at edge N+1.
  - Load enqueued at edge N → earliest writeEnb after edge N+1.
- Simultaneous push and pop: allowed in the same cycle. When full, a pop frees a slot only for the next cycle, since ld_ready uses pre-edge count.
- Starvation counter:
  - Increments when the head is live and the ALU wins the port, saturating at STARVE_MAX.
  - Clears when a load is written or the FIFO becomes empty.
- stall_req = (count==DEPTH) || (starve_cnt>=STARVE_MAX). It is combinational from registered state only.
- If alu_valid=1 while stall_req=1: the ALU still wins and proto_err is set sticky until reset.
- chk_pend1/2 are combinational:
  - chk_pendN = OR over live entries of (entry.reg==chk_regN).
  - Address 0 always returns 0.
  - Dead entries and the output register are not included; decode covers the output register via its own 1-stage forwarding.
- Pointers wrap modulo DEPTH. count is REG_W-independent, width clog2(DEPTH)+1.
- Reset asserted mid-operation discards all queued loads; no partial write is emitted.

Decomposition:
- Shared package wb_pkg:
  - REG_W, DATA_W, REG_ZERO=0.
  - Typedef wb_entry_t {live, reg, data}.
- Sub-module wb_load_fifo:
  - Circular buffer with per-entry live bits, kill-by-address port, and two CAM match ports.
  - Pop, push, count, full/empty.
- Top level wb_port_arbiter: select logic, starvation counter, output register, proto_err.

Test Plan:
1. Reset with rst pulsed asynchronously mid-cycle → all outputs 0, ld_ready=1 immediately, no writeEnb pulse.
2. ALU only: alu_reg=3, alu_data=0xDEADBEEF → next cycle writeEnb=1, writeReg=3, writeData=0xDEADBEEF; alu_reg=0 → writeEnb=0.
3. Load drain: enqueue loads reg5=0x11, reg6=0x22 with alu_valid=0 → writes to 5 then 6 on consecutive cycles; chk_reg1=6 reads pend=1 until its pop.
4. Kill: queue load reg7=0xAA, then ALU write reg7=0x55 before drain → only 0x55 written to reg7; the dead head pops with no writeEnb; chk_pend for 7 drops the cycle after the ALU write.
5. Full/backpressure: DEPTH=4, five loads while ALU busy → ld_ready=0 after four, stall_req=1; ALU idles → drain order preserved, fifth accepted one cycle after the first pop.
6. Starvation: one live load plus continuous ALU for 8 cycles → stall_req=1 on cycle 9; bench keeps alu_valid high → proto_err=1 sticky; release → load written, stall_req=0.
